// File: rtl/ex_stage.sv
// Execute stage: ALU + radix-2 mul/div; ALU 1 cycle, iterative ops 34 cycles, o_EX_BUSY stalls upstream.
// Define EX_FAST_MUL_EN to make MUL/MULH single-cycle; DIV/REM stay iterative.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         EX_FLUSH,
  input  logic [7:0]   EX_CTRL,
  input  logic         MEM_CTRL,
  input  logic [4:0]   WB_CTRL,
  input  logic [100:0] EX_DATA,
  output logic         o_MEM_CTRL,
  output logic [4:0]   o_WB_CTRL,
  output logic [68:0]  o_MEM_DATA,
  output logic         o_EX_BUSY
);
  localparam logic [2:0] MD_MUL  = 3'd1;
  localparam logic [2:0] MD_MULH = 3'd2;
  localparam logic [2:0] MD_DIV  = 3'd3;
  localparam logic [2:0] MD_DIVU = 3'd4;
  localparam logic [2:0] MD_REM  = 3'd5;
  localparam logic [2:0] MD_REMU = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] mag_a_q, mag_b_q, hi_q, lo_q;
  logic        sa_q, sb_q;

  logic        alu_src;
  logic [2:0]  md_op;
  logic [3:0]  alu_op;
  logic [4:0]  rw;
  logic [31:0] rd1, rd2, imm, op_a, op_b;
  logic        md_iter, md_signed, md_is_mul;

  assign alu_src = EX_CTRL[7];
  assign md_op   = EX_CTRL[6:4];
  assign alu_op  = EX_CTRL[3:0];
  assign rw      = EX_DATA[100:96];
  assign rd1     = EX_DATA[95:64];
  assign rd2     = EX_DATA[63:32];
  assign imm     = EX_DATA[31:0];
  assign op_a    = rd1;
  assign op_b    = alu_src ? imm : rd2;

`ifdef EX_FAST_MUL_EN
  assign md_iter = (md_op >= MD_DIV) && (md_op <= MD_REMU);
`else
  assign md_iter = (md_op >= MD_MUL) && (md_op <= MD_REMU);
`endif
  assign md_signed = (md_op == MD_MUL) || (md_op == MD_MULH) || (md_op == MD_DIV) || (md_op == MD_REM);
  assign md_is_mul = (md_op == MD_MUL) || (md_op == MD_MULH);

  assign o_EX_BUSY = rst && !EX_FLUSH && (((state == IDLE) && md_iter) || (state == BUSY));

  // Single-cycle ALU
  logic [31:0] alu_res, sc_res;
  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd6:    alu_res = {31'd0, op_a < op_b};
      4'd7:    alu_res = op_a << op_b[4:0];
      4'd8:    alu_res = op_a >> op_b[4:0];
      4'd9:    alu_res = $signed(op_a) >>> op_b[4:0];
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
  always_comb begin
    sc_res = alu_res;
    if (md_op == MD_MUL)       sc_res = fast_prod[31:0];
    else if (md_op == MD_MULH) sc_res = fast_prod[63:32];
  end
`else
  assign sc_res = alu_res;
`endif

  // Operand magnitudes captured at accept; signs are reapplied when the result is formed.
  logic        in_sa, in_sb;
  logic [31:0] in_mag_a, in_mag_b;
  assign in_sa    = md_signed & op_a[31];
  assign in_sb    = md_signed & op_b[31];
  assign in_mag_a = in_sa ? -op_a : op_a;
  assign in_mag_b = in_sb ? -op_b : op_b;

  logic        q_is_mul;
  logic [32:0] div_sh, mul_sum;
  logic        div_ge;
  assign q_is_mul = (op_q == MD_MUL) || (op_q == MD_MULH);
  assign div_sh   = {hi_q, lo_q[31]};
  assign div_ge   = div_sh >= {1'b0, mag_b_q};
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : 33'd0);

  logic [63:0] prod_mag, prod_fix;
  logic [31:0] md_res;
  assign prod_mag = {hi_q, lo_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod_mag : prod_mag;

  // A zero divisor forces an all-ones quotient; the remainder path already restores the dividend.
  always_comb begin
    md_res = '0;
    case (op_q)
      MD_MUL:          md_res = prod_fix[31:0];
      MD_MULH:         md_res = prod_fix[63:32];
      MD_DIV, MD_DIVU: md_res = (mag_b_q == 32'd0) ? 32'hFFFF_FFFF : ((sa_q ^ sb_q) ? -lo_q : lo_q);
      MD_REM, MD_REMU: md_res = sa_q ? -hi_q : hi_q;
      default:         md_res = '0;
    endcase
  end

  logic [31:0] ex_out;
  assign ex_out = (state == DONE) ? md_res : sc_res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_MEM_CTRL <= 1'b0;
      o_WB_CTRL  <= '0;
      o_MEM_DATA <= '0;
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
    end else begin
      if (EX_FLUSH || o_EX_BUSY) begin
        o_MEM_CTRL <= 1'b0;
        o_WB_CTRL  <= '0;
        o_MEM_DATA <= '0;
      end else begin
        o_MEM_CTRL <= MEM_CTRL;
        o_WB_CTRL  <= WB_CTRL;
        o_MEM_DATA <= {rw, ex_out, rd2};
      end

      if (EX_FLUSH) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (md_iter) begin
              op_q    <= md_op;
              sa_q    <= in_sa;
              sb_q    <= in_sb;
              mag_a_q <= in_mag_a;
              mag_b_q <= in_mag_b;
              hi_q    <= '0;
              lo_q    <= md_is_mul ? in_mag_b : in_mag_a;
              cnt     <= '0;
              state   <= BUSY;
            end
          end
          BUSY: begin
            if (q_is_mul) begin
              hi_q <= mul_sum[32:1];
              lo_q <= {mul_sum[0], lo_q[31:1]};
            end else if (div_ge) begin
              hi_q <= div_sh[31:0] - mag_b_q;
              lo_q <= {lo_q[30:0], 1'b1};
            end else begin
              hi_q <= div_sh[31:0];
              lo_q <= {lo_q[30:0], 1'b0};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, iterative mul/div corner cases, flush and reset aborts.
module tb_ex_stage;
  logic         clk;
  logic         rst;
  logic         EX_FLUSH;
  logic [7:0]   EX_CTRL;
  logic         MEM_CTRL;
  logic [4:0]   WB_CTRL;
  logic [100:0] EX_DATA;
  logic         o_MEM_CTRL;
  logic [4:0]   o_WB_CTRL;
  logic [68:0]  o_MEM_DATA;
  logic         o_EX_BUSY;

  int checks = 0;
  int errors = 0;

`ifdef EX_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .EX_FLUSH   (EX_FLUSH),
    .EX_CTRL    (EX_CTRL),
    .MEM_CTRL   (MEM_CTRL),
    .WB_CTRL    (WB_CTRL),
    .EX_DATA    (EX_DATA),
    .o_MEM_CTRL (o_MEM_CTRL),
    .o_WB_CTRL  (o_WB_CTRL),
    .o_MEM_DATA (o_MEM_DATA),
    .o_EX_BUSY  (o_EX_BUSY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    EX_CTRL  = 8'h00;
    MEM_CTRL = 1'b0;
    WB_CTRL  = 5'h00;
    EX_DATA  = '0;
  endtask

  // Presents one instruction, holds it while busy, then checks latency, bubbles and result.
  task automatic run_op(input string tag, input logic [7:0] ctrl, input logic mem, input logic [4:0] wb,
                        input logic [4:0] rw, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] res, input int lat);
    int   edges;
    int   busy_cyc;
    int   bad_bub;
    logic done;
    EX_CTRL  = ctrl;
    MEM_CTRL = mem;
    WB_CTRL  = wb;
    EX_DATA  = {rw, rd1, rd2, imm};
    edges    = 0;
    busy_cyc = 0;
    bad_bub  = 0;
    done     = 1'b0;
    while (!done && edges < 200) begin
      #1;
      if (o_EX_BUSY) busy_cyc++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      edges++;
      if (!done && ({o_MEM_CTRL, o_WB_CTRL, o_MEM_DATA} != '0)) bad_bub++;
    end
    check({tag, " latency"}, 80'(edges), 80'(lat));
    check({tag, " busy cycles"}, 80'(busy_cyc), 80'(lat - 1));
    check({tag, " bubbles"}, 80'(bad_bub), 80'd0);
    check({tag, " data"}, 80'(o_MEM_DATA), 80'({rw, res, rd2}));
    check({tag, " ctrl"}, 80'({o_MEM_CTRL, o_WB_CTRL}), 80'({mem, wb}));
    idle_inputs();
  endtask

  initial begin
    rst      = 1'b0;
    EX_FLUSH = 1'b0;
    EX_CTRL  = 8'h30;
    MEM_CTRL = 1'b1;
    WB_CTRL  = 5'h1F;
    EX_DATA  = {5'd1, 32'd10, 32'd3, 32'd0};
    #12;
    check("reset busy", 80'(o_EX_BUSY), 80'd0);
    check("reset outputs", 80'({o_MEM_CTRL, o_WB_CTRL, o_MEM_DATA}), 80'd0);
    idle_inputs();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    run_op("add",   8'h00, 1'b0, 5'h10, 5'd3, 32'd5, 32'd7, 32'd0, 32'd12, 1);
    run_op("sub",   8'h01, 1'b1, 5'h01, 5'd4, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE, 1);
    run_op("xor",   8'h04, 1'b0, 5'h11, 5'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'hFF00_0FF0, 1);
    run_op("slt",   8'h05, 1'b0, 5'h10, 5'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1);
    run_op("sltu",  8'h06, 1'b0, 5'h10, 5'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1);
    run_op("sra",   8'h09, 1'b0, 5'h10, 5'd8, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000, 1);
    run_op("srl",   8'h08, 1'b0, 5'h10, 5'd8, 32'h8000_0000, 32'd4, 32'd0, 32'h0800_0000, 1);
    run_op("slli",  8'h87, 1'b0, 5'h10, 5'd9, 32'd1, 32'd2, 32'd31, 32'h8000_0000, 1);
    run_op("passb", 8'h8A, 1'b0, 5'h10, 5'd10, 32'd9, 32'd2, 32'h1234, 32'h1234, 1);
    run_op("op12",  8'h0C, 1'b0, 5'h10, 5'd11, 32'd9, 32'd2, 32'd0, 32'd0, 1);
    run_op("md7",   8'h70, 1'b0, 5'h10, 5'd12, 32'd2, 32'd3, 32'd0, 32'd5, 1);

    run_op("div",   8'h30, 1'b0, 5'h10, 5'd13, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFD, 34);
    run_op("rem",   8'h50, 1'b0, 5'h10, 5'd14, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFF, 34);
    run_op("divu0", 8'h40, 1'b0, 5'h10, 5'd15, 32'd100, 32'd0, 32'd0, 32'hFFFF_FFFF, 34);
    run_op("remu0", 8'h60, 1'b0, 5'h10, 5'd16, 32'd100, 32'd0, 32'd0, 32'd100, 34);
    run_op("divov", 8'h30, 1'b0, 5'h10, 5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);
    run_op("remov", 8'h50, 1'b0, 5'h10, 5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 34);
    run_op("mul",   8'h10, 1'b1, 5'h12, 5'd19, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, MUL_LAT);
    run_op("mulh",  8'h20, 1'b0, 5'h10, 5'd20, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, MUL_LAT);
    run_op("mulneg", 8'h10, 1'b0, 5'h10, 5'd21, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'hFFFF_FFF1, MUL_LAT);

    // Flush on a plain ALU op must replace the result with a bubble.
    run_op("add2",  8'h00, 1'b0, 5'h10, 5'd3, 32'd1, 32'd1, 32'd0, 32'd2, 1);
    EX_CTRL  = 8'h00;
    WB_CTRL  = 5'h10;
    EX_DATA  = {5'd3, 32'd4, 32'd4, 32'd0};
    EX_FLUSH = 1'b1;
    @(posedge clk);
    #1;
    EX_FLUSH = 1'b0;
    check("flush alu bubble", 80'({o_MEM_CTRL, o_WB_CTRL, o_MEM_DATA}), 80'd0);
    idle_inputs();

    // Flush in the middle of a DIVU.
    EX_CTRL = 8'h40;
    EX_DATA = {5'd2, 32'd1000, 32'd7, 32'd0};
    repeat (11) @(posedge clk);
    #1;
    check("divu busy before flush", 80'(o_EX_BUSY), 80'd1);
    EX_FLUSH = 1'b1;
    #1;
    check("busy during flush", 80'(o_EX_BUSY), 80'd0);
    @(posedge clk);
    #1;
    EX_FLUSH = 1'b0;
    check("flush div bubble", 80'({o_MEM_CTRL, o_WB_CTRL, o_MEM_DATA}), 80'd0);
    idle_inputs();
    run_op("add after flush", 8'h00, 1'b0, 5'h10, 5'd3, 32'd5, 32'd7, 32'd0, 32'd12, 1);

    // Reset clears live outputs asynchronously.
    #2 rst = 1'b0;
    #1;
    check("async reset outputs", 80'({o_MEM_CTRL, o_WB_CTRL, o_MEM_DATA}), 80'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a DIVU, then a fresh DIVU must take the full latency.
    EX_CTRL = 8'h40;
    EX_DATA = {5'd2, 32'd1000, 32'd7, 32'd0};
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("busy during reset", 80'(o_EX_BUSY), 80'd0);
    check("mid-op reset outputs", 80'({o_MEM_CTRL, o_WB_CTRL, o_MEM_DATA}), 80'd0);
    #1 rst = 1'b1;
    run_op("divu after reset", 8'h40, 1'b0, 5'h10, 5'd22, 32'd9, 32'd3, 32'd0, 32'd3, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
